matrix_key_scan: RTL

// - Scanned-input counterpart of the dynamic 7-seg digit scanner: drives a 4x4 matrix keypad row by row, reads the columns back, debounces, and reports one key code per press.
// - Sits between keypad pins and the display/control logic; key_code/key_valid feed the digit-value registers shown on the scanned display.

---
 rtl/matrix_key_scan_pkg.sv | 42 ++++
 rtl/matrix_key_scan_tick_gen.sv | 27 ++
 rtl/matrix_key_scan.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/matrix_key_scan_pkg.sv
// Shared definitions for the matrix keypad scanner: FSM encodings, row reset
// pattern, frame-result encodings and the frame classifier.
package matrix_key_scan_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK = 2'd1;
  localparam logic [1:0] ST_PRESSED   = 2'd2;
  localparam logic [1:0] ST_REL_CHK   = 2'd3;

  localparam logic [3:0] ROW_RESET = 4'b1110;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } res_e;

  typedef struct packed {
    res_e       res;
    logic [3:0] code;
  } frame_res_t;

  // Samples are active low, bit index = row*4+col. Only the first low bit's
  // index matters, and the low count only needs to distinguish 0, 1 and >=2.
  function automatic frame_res_t frame_eval(input logic [15:0] samples);
    frame_res_t r;
    logic [1:0] n_low;
    r.res  = RES_NONE;
    r.code = 4'd0;
    n_low  = 2'd0;
    for (int i = 0; i < 16; i++) begin
      if (!samples[i]) begin
        if (n_low == 2'd0) r.code = 4'(i);
        if (n_low != 2'd2) n_low = n_low + 2'd1;
      end
    end
    if (n_low == 2'd1)      r.res = RES_SINGLE;
    else if (n_low == 2'd2) r.res = RES_MULTI;
    return r;
  endfunction

endpackage

// File: rtl/matrix_key_scan_tick_gen.sv
// Free-running slot counter; pulses o_slot_end on the last clock of each
// row slot. Shared with the display digit scanner.
module scan_tick_gen #(
  parameter logic [15:0] CNT_MAX = 16'd50_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_slot_end
);

  logic [15:0] r_cnt;
  logic        w_last;

  assign w_last     = (r_cnt == CNT_MAX - 16'd1);
  assign o_slot_end = w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 16'd0;
    end else if (w_last) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/matrix_key_scan.sv
// 4x4 matrix keypad scanner: one-cold row drive, synchronized column
// readback, frame-level debounce and one key_valid pulse per accepted press.
module matrix_key_scan
  import matrix_key_scan_pkg::*;
#(
  parameter logic [15:0] CNT_SCAN = 16'd50_000,
  parameter logic [3:0]  DEBOUNCE = 4'd5
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  logic [3:0]  r_col_p1;
  logic [3:0]  r_col_p2;
  logic [3:0]  r_row;
  logic [1:0]  r_row_idx;
  logic [11:0] r_frame;
  logic [3:0]  r_dcnt;
  res_e        r_last_res;
  logic [3:0]  r_last_code;
  logic [1:0]  r_state;
  logic [3:0]  r_code;
  logic        r_valid;
  logic        r_pressed;

  logic        w_slot_end;
  logic        w_frame_end;
  logic [15:0] w_frame_now;
  frame_res_t  w_eval;
  logic        w_same;
  logic [3:0]  w_dcnt_next;
  logic        w_hit;
  logic [1:0]  w_state_nxt;
  logic        w_accept;
  logic        w_release;

  scan_tick_gen #(
    .CNT_MAX (CNT_SCAN)
  ) u_tick (
    .i_clk      (sys_clk),
    .i_rst_n    (sys_rst_n),
    .o_slot_end (w_slot_end)
  );

  assign key_row     = r_row;
  assign key_code    = r_code;
  assign key_valid   = r_valid;
  assign key_pressed = r_pressed;

  // key_col is asynchronous to sys_clk; nothing downstream sees it unsynchronized
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_col_p1 <= 4'hF;
      r_col_p2 <= 4'hF;
    end else begin
      r_col_p1 <= key_col;
      r_col_p2 <= r_col_p1;
    end
  end

  // Row 3 is never stored: its columns are classified directly at frame close
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_row     <= ROW_RESET;
      r_row_idx <= 2'd0;
      r_frame   <= 12'hFFF;
    end else if (w_slot_end) begin
      case (r_row_idx)
        2'd0:    r_frame[3:0]  <= r_col_p2;
        2'd1:    r_frame[7:4]  <= r_col_p2;
        2'd2:    r_frame[11:8] <= r_col_p2;
        default: r_frame       <= r_frame;
      endcase
      r_row     <= {r_row[2:0], r_row[3]};
      r_row_idx <= r_row_idx + 2'd1;
    end
  end

  assign w_frame_end = w_slot_end && (r_row_idx == 2'd3);
  assign w_frame_now = {r_col_p2, r_frame};
  assign w_eval      = frame_eval(w_frame_now);

  assign w_same = (w_eval.res == r_last_res) &&
                  ((w_eval.res != RES_SINGLE) || (w_eval.code == r_last_code));

  always_comb begin
    w_dcnt_next = 4'd1;
    if (w_same) begin
      if (r_dcnt >= DEBOUNCE) w_dcnt_next = DEBOUNCE;
      else                    w_dcnt_next = r_dcnt + 4'd1;
    end
  end

  assign w_hit = (w_dcnt_next >= DEBOUNCE);

  // A code change in PRESS_CHK reloads the counter to 1, so w_hit there
  // always means DEBOUNCE frames of one and the same key.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_eval.res == RES_SINGLE) w_state_nxt = ST_PRESS_CHK;
      end
      ST_PRESS_CHK: begin
        if (w_eval.res != RES_SINGLE) begin
          w_state_nxt = ST_IDLE;
        end else if (w_hit) begin
          w_state_nxt = ST_PRESSED;
          w_accept    = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (w_eval.res == RES_NONE) w_state_nxt = ST_REL_CHK;
      end
      ST_REL_CHK: begin
        if (w_eval.res != RES_NONE) begin
          w_state_nxt = ST_PRESSED;
        end else if (w_hit) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_dcnt      <= 4'd0;
      r_last_res  <= RES_NONE;
      r_last_code <= 4'd0;
      r_state     <= ST_IDLE;
    end else if (w_frame_end) begin
      r_dcnt      <= w_dcnt_next;
      r_last_res  <= w_eval.res;
      r_last_code <= w_eval.code;
      r_state     <= w_state_nxt;
    end
  end

  // key_valid is cleared every clock so an accepted press yields one pulse
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_code    <= 4'd0;
      r_valid   <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_frame_end && w_accept) begin
        r_code    <= w_eval.code;
        r_valid   <= 1'b1;
        r_pressed <= 1'b1;
      end else if (w_frame_end && w_release) begin
        r_pressed <= 1'b0;
      end
    end
  end

endmodule
